// File: rtl/bht_access_sequencer_if.sv
// Bundles the prediction, update and table-port signals of bht_access_sequencer.
//   slave  : the sequencer's view (takes requests, drives the table port)
//   master : the environment's view (requesters plus the table memory)
// Signals:
//   pred_valid/pred_pc/pred_ready             prediction request handshake
//   pred_resp_valid/pred_taken                prediction result, one cycle after grant
//   upd_valid/upd_pc/upd_taken/upd_ready      resolved-branch update handshake
//   tbl_en/tbl_we/tbl_addr/tbl_wdata/tbl_rdata single-port table access
//   init_done                                 table sweep complete
interface bht_access_sequencer_if #(
  parameter int unsigned M    = 64,
  parameter int unsigned N    = 2,
  parameter int unsigned PC_W = 9
);
  localparam int unsigned IdxW = $clog2(M);

  logic            pred_valid;
  logic [PC_W-1:0] pred_pc;
  logic            pred_ready;
  logic            pred_resp_valid;
  logic            pred_taken;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic            upd_ready;
  logic            tbl_en;
  logic            tbl_we;
  logic [IdxW-1:0] tbl_addr;
  logic [N-1:0]    tbl_wdata;
  logic [N-1:0]    tbl_rdata;
  logic            init_done;

  modport slave (
    input  pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, tbl_rdata,
    output pred_ready, pred_resp_valid, pred_taken, upd_ready,
           tbl_en, tbl_we, tbl_addr, tbl_wdata, init_done
  );

  modport master (
    output pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, tbl_rdata,
    input  pred_ready, pred_resp_valid, pred_taken, upd_ready,
           tbl_en, tbl_we, tbl_addr, tbl_wdata, init_done
  );
endinterface

// File: rtl/bht_access_sequencer.sv
// Access sequencer for a single-port branch history table of M saturating N-bit counters.
// After reset it sweeps every entry to weakly-not-taken, then arbitrates the table port
// between fetch-side prediction reads and queued read-modify-write counter updates.
// Ports:
//   clk_i   clock, all state on the rising edge
//   rst_ni  asynchronous active-low reset; forces every output to 0 while low
//   bus     bht_access_sequencer_if.slave (prediction, update and table-port signals)
module bht_access_sequencer #(
  parameter int unsigned M       = 64,
  parameter int unsigned N       = 2,
  parameter int unsigned PC_W    = 9,
  parameter int unsigned Q_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  bht_access_sequencer_if.slave bus
);

  localparam int unsigned IdxW = $clog2(M);
  localparam int unsigned PtrW = $clog2(Q_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [CntW-1:0] QFull   = CntW'(Q_DEPTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(M - 1);
  localparam logic [N-1:0]    WeakNt  = N'((1 << (N - 1)) - 1);
  localparam logic [N-1:0]    CntMax  = {N{1'b1}};

  localparam logic [1:0] StInit  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StUpdWb = 2'd2;

  typedef struct packed {
    logic [IdxW-1:0] idx;
    logic            taken;
  } upd_entry_t;

  logic [1:0]      state_q, state_d;
  logic [IdxW-1:0] sweep_q, sweep_d;
  logic            init_done_q, init_done_d;
  logic            resp_q, resp_d;
  upd_entry_t      wb_q, wb_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  upd_entry_t      mem_q [Q_DEPTH];

  logic            full, empty, is_run;
  logic            upd_ready, push, pop;
  logic            grant_upd, grant_pred;
  upd_entry_t      head, in_entry;
  logic [IdxW-1:0] pred_idx;
  logic [N-1:0]    sat_val;
  logic            tbl_en, tbl_we;
  logic [IdxW-1:0] tbl_addr;
  logic [N-1:0]    tbl_wdata;

  // Only the low PC bits index the table; the rest are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pred_pc[PC_W-1:IdxW], bus.upd_pc[PC_W-1:IdxW]};

  assign pred_idx       = bus.pred_pc[IdxW-1:0];
  assign in_entry.idx   = bus.upd_pc[IdxW-1:0];
  assign in_entry.taken = bus.upd_taken;

  assign full   = (count_q == QFull);
  assign empty  = (count_q == '0);
  assign is_run = (state_q == StRun);
  assign head   = mem_q[rd_ptr_q];

  // A full queue never accepts, even while popping: no push-through.
  assign upd_ready = rst_ni & ~full;
  assign push      = bus.upd_valid & upd_ready;

  // Full queue beats predictions so resolved updates cannot be starved.
  assign grant_upd  = is_run & (full | (~bus.pred_valid & ~empty));
  assign grant_pred = is_run & ~full & bus.pred_valid;
  assign pop        = grant_upd;

  // Saturating increment/decrement of the counter read in the previous cycle.
  always_comb begin
    sat_val = bus.tbl_rdata;
    if (wb_q.taken) begin
      if (bus.tbl_rdata != CntMax) sat_val = bus.tbl_rdata + N'(1);
    end else begin
      if (bus.tbl_rdata != '0) sat_val = bus.tbl_rdata - N'(1);
    end
  end

  // Control FSM and sweep address.
  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    init_done_d = init_done_q;
    case (state_q)
      StInit: begin
        sweep_d = sweep_q + IdxW'(1);
        if (sweep_q == LastIdx) begin
          state_d     = StRun;
          init_done_d = 1'b1;
        end
      end
      StRun: begin
        if (grant_upd) state_d = StUpdWb;
      end
      StUpdWb: begin
        state_d = StRun;
      end
      default: begin
        state_d = StInit;
        sweep_d = '0;
      end
    endcase
  end

  // Queue bookkeeping and the entry carried into the write-back cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CntW'(push) - CntW'(pop);
    wb_d     = grant_upd ? head : wb_q;
    resp_d   = grant_pred;
  end

  // Table port drive; everything is held at 0 while reset is asserted.
  always_comb begin
    tbl_en    = 1'b0;
    tbl_we    = 1'b0;
    tbl_addr  = '0;
    tbl_wdata = '0;
    if (rst_ni) begin
      case (state_q)
        StInit: begin
          tbl_en    = 1'b1;
          tbl_we    = 1'b1;
          tbl_addr  = sweep_q;
          tbl_wdata = WeakNt;
        end
        StRun: begin
          if (grant_upd) begin
            tbl_en   = 1'b1;
            tbl_addr = head.idx;
          end else if (grant_pred) begin
            tbl_en   = 1'b1;
            tbl_addr = pred_idx;
          end
        end
        StUpdWb: begin
          tbl_en    = 1'b1;
          tbl_we    = 1'b1;
          tbl_addr  = wb_q.idx;
          tbl_wdata = sat_val;
        end
        default: begin
          tbl_en = 1'b0;
        end
      endcase
    end
  end

  assign bus.tbl_en          = tbl_en;
  assign bus.tbl_we          = tbl_we;
  assign bus.tbl_addr        = tbl_addr;
  assign bus.tbl_wdata       = tbl_wdata;
  assign bus.upd_ready       = upd_ready;
  assign bus.pred_ready      = rst_ni & is_run & ~full;
  assign bus.pred_resp_valid = resp_q;
  assign bus.pred_taken      = resp_q & bus.tbl_rdata[N-1];
  assign bus.init_done       = init_done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StInit;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
      resp_q      <= 1'b0;
      wb_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      init_done_q <= init_done_d;
      resp_q      <= resp_d;
      wb_q        <= wb_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Q_DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

endmodule

// File: tb/tb_bht_access_sequencer.sv
// Directed self-checking bench for bht_access_sequencer (M=64, N=2, PC_W=9, Q_DEPTH=4).
// A behavioural single-port table memory answers the DUT's table port.
module tb_bht_access_sequencer;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  logic [1:0] tmem [64];

  bht_access_sequencer_if bus_if ();

  bht_access_sequencer dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table memory: write on we, registered read data otherwise.
  always @(posedge clk) begin
    if (bus_if.tbl_en) begin
      if (bus_if.tbl_we) tmem[bus_if.tbl_addr] <= bus_if.tbl_wdata;
      else               bus_if.tbl_rdata <= tmem[bus_if.tbl_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " tbl_en"},    32'(bus_if.tbl_en), 0);
    check({tag, " tbl_we"},    32'(bus_if.tbl_we), 0);
    check({tag, " tbl_addr"},  32'(bus_if.tbl_addr), 0);
    check({tag, " tbl_wdata"}, 32'(bus_if.tbl_wdata), 0);
    check({tag, " pred_rdy"},  32'(bus_if.pred_ready), 0);
    check({tag, " upd_rdy"},   32'(bus_if.upd_ready), 0);
    check({tag, " resp_vld"},  32'(bus_if.pred_resp_valid), 0);
    check({tag, " pred_tkn"},  32'(bus_if.pred_taken), 0);
    check({tag, " init_done"}, 32'(bus_if.init_done), 0);
  endtask

  // Single queued update on an otherwise idle RUN port: read then write-back.
  task automatic do_upd(input logic [8:0] pc, input logic taken, input logic [1:0] exp_w);
    bus_if.upd_valid = 1'b1;
    bus_if.upd_pc    = pc;
    bus_if.upd_taken = taken;
    #1;
    check("upd accept", 32'(bus_if.upd_ready), 1);
    cyc();
    bus_if.upd_valid = 1'b0;
    #1;
    check("upd rd en",   32'(bus_if.tbl_en), 1);
    check("upd rd we",   32'(bus_if.tbl_we), 0);
    check("upd rd addr", 32'(bus_if.tbl_addr), 32'(pc[5:0]));
    cyc();
    check("upd wb we",    32'(bus_if.tbl_we), 1);
    check("upd wb addr",  32'(bus_if.tbl_addr), 32'(pc[5:0]));
    check("upd wb wdata", 32'(bus_if.tbl_wdata), 32'(exp_w));
    check("upd wb prdy",  32'(bus_if.pred_ready), 0);
    cyc();
  endtask

  task automatic do_pred(input logic [8:0] pc, input logic exp_taken);
    bus_if.pred_valid = 1'b1;
    bus_if.pred_pc    = pc;
    #1;
    check("pred rd addr", 32'(bus_if.tbl_addr), 32'(pc[5:0]));
    cyc();
    bus_if.pred_valid = 1'b0;
    #1;
    check("pred resp vld", 32'(bus_if.pred_resp_valid), 1);
    check("pred taken",    32'(bus_if.pred_taken), 32'(exp_taken));
  endtask

  logic [5:0] drain_addr [4];
  logic [1:0] drain_wd   [4];

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    bus_if.pred_valid = 1'b0;
    bus_if.pred_pc    = '0;
    bus_if.upd_valid  = 1'b0;
    bus_if.upd_pc     = '0;
    bus_if.upd_taken  = 1'b0;
    bus_if.tbl_rdata  = '0;

    // 1: reset state, then the initialisation sweep.
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("rst");
    #1 rst_n = 1'b1;
    #1;
    for (int i = 0; i < 64; i++) begin
      check("init en",    32'(bus_if.tbl_en), 1);
      check("init we",    32'(bus_if.tbl_we), 1);
      check("init addr",  32'(bus_if.tbl_addr), i);
      check("init wdata", 32'(bus_if.tbl_wdata), 1);
      check("init resp",  32'(bus_if.pred_resp_valid), 0);
      check("init prdy",  32'(bus_if.pred_ready), 0);
      cyc();
    end
    check("init_done",   32'(bus_if.init_done), 1);
    check("run prdy",    32'(bus_if.pred_ready), 1);
    check("run idle en", 32'(bus_if.tbl_en), 0);
    check("run urdy",    32'(bus_if.upd_ready), 1);
    check("tmem 63",     32'(tmem[63]), 1);

    // 2: first prediction on a freshly initialised entry.
    bus_if.pred_valid = 1'b1;
    bus_if.pred_pc    = 9'h1A5;
    #1;
    check("p2 en",   32'(bus_if.tbl_en), 1);
    check("p2 we",   32'(bus_if.tbl_we), 0);
    check("p2 addr", 32'(bus_if.tbl_addr), 32'h25);
    cyc();
    bus_if.pred_valid = 1'b0;
    #1;
    check("p2 resp vld", 32'(bus_if.pred_resp_valid), 1);
    check("p2 taken",    32'(bus_if.pred_taken), 0);
    check("p2 idle",     32'(bus_if.tbl_en), 0);

    // 3: counter walk with saturation at both ends.
    do_upd(9'h025, 1'b1, 2'd2);
    do_upd(9'h025, 1'b1, 2'd3);
    do_upd(9'h025, 1'b1, 2'd3);
    do_pred(9'h025, 1'b1);
    do_upd(9'h025, 1'b0, 2'd2);
    do_upd(9'h025, 1'b0, 2'd1);
    do_upd(9'h025, 1'b0, 2'd0);
    do_upd(9'h025, 1'b0, 2'd0);
    do_pred(9'h025, 1'b0);

    // 4: predictions held while the queue fills; a full queue takes the port.
    for (int k = 0; k < 4; k++) begin
      bus_if.pred_valid = 1'b1;
      bus_if.pred_pc    = 9'h001;
      bus_if.upd_valid  = 1'b1;
      bus_if.upd_pc     = 9'(2 + k);
      bus_if.upd_taken  = 1'b1;
      #1;
      check("qf urdy", 32'(bus_if.upd_ready), 1);
      check("qf addr", 32'(bus_if.tbl_addr), 1);
      check("qf we",   32'(bus_if.tbl_we), 0);
      cyc();
    end
    bus_if.upd_valid = 1'b0;
    #1;
    check("qf full urdy", 32'(bus_if.upd_ready), 0);
    check("qf full prdy", 32'(bus_if.pred_ready), 0);
    check("qf rd en",     32'(bus_if.tbl_en), 1);
    check("qf rd we",     32'(bus_if.tbl_we), 0);
    check("qf rd addr",   32'(bus_if.tbl_addr), 2);
    check("qf resp vld",  32'(bus_if.pred_resp_valid), 1);
    cyc();
    check("qf wb we",    32'(bus_if.tbl_we), 1);
    check("qf wb addr",  32'(bus_if.tbl_addr), 2);
    check("qf wb wdata", 32'(bus_if.tbl_wdata), 2);
    check("qf wb prdy",  32'(bus_if.pred_ready), 0);
    check("qf wb resp",  32'(bus_if.pred_resp_valid), 0);
    cyc();
    check("qf pred prdy", 32'(bus_if.pred_ready), 1);
    check("qf pred addr", 32'(bus_if.tbl_addr), 1);
    check("qf pred we",   32'(bus_if.tbl_we), 0);
    cyc();
    bus_if.pred_valid = 1'b0;
    #1;
    check("qf rd2 addr", 32'(bus_if.tbl_addr), 3);
    check("qf rd2 we",   32'(bus_if.tbl_we), 0);
    cyc();
    check("qf wb2 we",    32'(bus_if.tbl_we), 1);
    check("qf wb2 addr",  32'(bus_if.tbl_addr), 3);
    check("qf wb2 wdata", 32'(bus_if.tbl_wdata), 2);

    // 6: asynchronous reset in the middle of a write-back cycle.
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("async rst");
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("rerst en",   32'(bus_if.tbl_en), 1);
    check("rerst we",   32'(bus_if.tbl_we), 1);
    check("rerst addr", 32'(bus_if.tbl_addr), 0);
    check("rerst urdy", 32'(bus_if.upd_ready), 1);
    check("rerst done", 32'(bus_if.init_done), 0);

    // 5: updates queued during the sweep drain in order once it ends.
    for (int i = 0; i < 64; i++) begin
      if (i < 5) begin
        bus_if.upd_valid = 1'b1;
        bus_if.upd_pc    = 9'(9'h010 + i);
        bus_if.upd_taken = (i != 2);
      end
      #1;
      check("sw addr", 32'(bus_if.tbl_addr), i);
      check("sw we",   32'(bus_if.tbl_we), 1);
      if (i < 4) check("sw urdy", 32'(bus_if.upd_ready), 1);
      if (i == 4) begin
        check("sw full urdy", 32'(bus_if.upd_ready), 0);
        bus_if.upd_valid = 1'b0;
      end
      cyc();
    end
    drain_addr[0] = 6'h10; drain_wd[0] = 2'd2;
    drain_addr[1] = 6'h11; drain_wd[1] = 2'd2;
    drain_addr[2] = 6'h12; drain_wd[2] = 2'd0;
    drain_addr[3] = 6'h13; drain_wd[3] = 2'd2;
    check("dr done", 32'(bus_if.init_done), 1);
    check("dr prdy", 32'(bus_if.pred_ready), 0);
    for (int j = 0; j < 4; j++) begin
      check("dr rd en",   32'(bus_if.tbl_en), 1);
      check("dr rd we",   32'(bus_if.tbl_we), 0);
      check("dr rd addr", 32'(bus_if.tbl_addr), 32'(drain_addr[j]));
      cyc();
      check("dr wb we",    32'(bus_if.tbl_we), 1);
      check("dr wb addr",  32'(bus_if.tbl_addr), 32'(drain_addr[j]));
      check("dr wb wdata", 32'(bus_if.tbl_wdata), 32'(drain_wd[j]));
      cyc();
    end
    check("dr idle", 32'(bus_if.tbl_en), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/bht_access_sequencer.md
Name: bht_access_sequencer

Overview:
Controller for a single-port branch history table of M saturating N-bit counters. After reset it sweeps the table to weakly-not-taken. It then shares the one table port between the fetch-side prediction requester and the resolve-side update requester. Resolved branches are buffered in a small update queue and applied as read-modify-write sequences.

Parameters:
M, 64, number of table entries (power of 2); IDX_W = log2(M)
N, 2, counter width in bits
PC_W, 9, width of the PC inputs
Q_DEPTH, 4, update queue depth (power of 2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
pred_valid  in  1  prediction request
pred_pc  in  PC_W  branch PC for prediction
pred_ready  out  1  prediction request accepted this cycle when pred_valid=1
pred_resp_valid  out  1  prediction result valid
pred_taken  out  1  predicted direction, counter MSB
upd_valid  in  1  resolved-branch update request
upd_pc  in  PC_W  resolved branch PC
upd_taken  in  1  actual outcome
upd_ready  out  1  update queue can accept
tbl_en  out  1  table port enable
tbl_we  out  1  table write enable (1 = write, 0 = read)
tbl_addr  out  IDX_W  table index
tbl_wdata  out  N  write data
tbl_rdata  in  N  read data, valid one cycle after a read
init_done  out  1  table sweep complete

Behaviour:
- Index derivation: index = pc[IDX_W-1:0] for both prediction and update.
- Reset (reset=0): takes effect immediately, even mid-operation. All outputs go to 0, queue is flushed, sweep address returns to 0, FSM enters INIT.
- FSM states: INIT, RUN, UPD_WB.
- INIT:
  - Sweep starts the first clock after reset release: one write per cycle, addr 0..M-1, tbl_en=1, tbl_we=1, tbl_wdata = 2^(N-1)-1.
  - After the addr M-1 write, go to RUN. init_done=1 from then until the next reset.
  - pred_ready=0 throughout INIT.
  - Updates are enqueued during INIT but not drained.
- RUN, per-cycle port grant:
  - If count == Q_DEPTH, the update read wins.
  - Else if pred_valid=1, the prediction read wins.
  - Else if count > 0, the update read wins.
  - Else the port is idle: tbl_en=0.
- pred_ready = (state == RUN) and not (count == Q_DEPTH). It is combinational.
- Prediction read:
  - Issue cycle t: tbl_en=1, tbl_we=0, tbl_addr = index.
  - Cycle t+1: pred_resp_valid=1 and pred_taken = tbl_rdata[N-1].
  - pred_taken=0 whenever pred_resp_valid=0.
  - Back-to-back predictions: one per cycle.
- Update read: issued at cycle t on the queue head, which is popped that cycle. Next state is UPD_WB.
- UPD_WB (cycle t+1):
  - Port writes the head's index: tbl_we=1.
  - tbl_wdata = tbl_rdata + 1 if taken, tbl_rdata - 1 if not taken.
  - Saturation: 2^N-1 stays with taken; 0 stays with not-taken.
  - pred_ready=0 in this cycle. Return to RUN.
  - Throughput: one update per 2 cycles.
- Queue:
  - FIFO of {index, taken}; count ranges 0..Q_DEPTH.
  - upd_ready = reset deasserted and count < Q_DEPTH.
  - When full, upd_ready=0 even in a pop cycle; no same-cycle push-through.
  - Simultaneous push and pop with count < Q_DEPTH: count unchanged, order preserved.
  - Pointers wrap modulo Q_DEPTH.
- Ordering: updates are applied in arrival order. Predictions may observe counters that do not yet include queued updates; no bypass.
- No illegal states: any unreachable encoding returns to INIT.

Test Plan:
1. Release reset:
   - Cycles 1..64 write addr 0..63 with wdata=1, tbl_we=1.
   - init_done=1 and pred_ready=1 from cycle 65.
   - pred_resp_valid stays 0 throughout.
2. After init, pred_valid with pred_pc=0x1A5:
   - tbl_addr=0x25 read.
   - Next cycle pred_resp_valid=1, pred_taken=0.
3. Counter walk on pc=0x025:
   - Three taken updates write 2, 3, 3 (saturate); a following prediction returns pred_taken=1.
   - Four not-taken updates write 2, 1, 0, 0.
4. Queue-full priority:
   - Hold pred_valid=1 and push 4 updates in consecutive cycles.
   - upd_ready drops after the 4th push.
   - The next grant is an update read despite pred_valid; pred_ready=0 in both the read and UPD_WB cycles.
5. Push 4 updates during INIT:
   - All accepted; a 5th sees upd_ready=0.
   - After init_done, they drain in order, with the first update read in the first RUN cycle.
6. Assert reset during an UPD_WB cycle:
   - All outputs are 0 immediately, without waiting for a clock edge.
   - After release, the queue is empty and the sweep restarts at addr 0.
